// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//   Shared definitions for the pipelined adder/subtractor.
//   - OP_ADD / OP_SUB : encoding of the per-transaction op input.
//   - chunk_width()   : bits of carry chain handled by one pipeline stage.
//   The stage record (stage_t) depends on WIDTH/STAGES and is therefore
//   declared inside addsub_pipe_nbit from its own localparams.
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Guarded so a bad STAGES value reaches the elaboration check in the top
    // instead of dying on a divide-by-zero first.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
//   Combinational CHUNK-bit ripple adder built from full_adder cells. One
//   instance per pipeline stage; the caller has already inverted b for a
//   subtract and supplies the stage carry-in.
//   Ports:
//     a_i     in  CHUNK  operand A chunk
//     b_i     in  CHUNK  operand B' chunk (B or ~B)
//     cin_i   in  1      carry into bit 0 of the chunk
//     sum_o   out CHUNK  chunk sum
//     cout_o  out 1      carry out of the chunk MSB
//     cmsb_o  out 1      carry into the chunk MSB (for signed overflow)
// -----------------------------------------------------------------------------
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a   (a_i[i]),
            .b   (b_i[i]),
            .cin (carry[i]),
            .sum (sum_o[i]),
            .cout(carry[i+1])
        );
    end

    assign cout_o = carry[CHUNK];
    assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell.
//   Ports:
//     a, b  in  operand bits
//     cin   in  carry in
//     sum   out sum bit
//     cout  out carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_pipe_nbit.sv
// -----------------------------------------------------------------------------
// addsub_pipe_nbit
//   Pipelined two's-complement adder/subtractor with valid/ready handshake.
//   The carry chain is cut into STAGES chunks of WIDTH/STAGES bits; each stage
//   adds one chunk using the carry registered by the previous stage. Subtract
//   is A + ~B + 1 (B XORed with op, carry-in = op). All stages advance
//   together when the output is empty or being accepted.
//   Parameters:
//     WIDTH   operand/result width (>= 2)
//     STAGES  pipeline stages; WIDTH % STAGES must be 0
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operands/op valid
//     in_ready   out  block accepts this cycle (= pipeline advance)
//     op         in   0 = add, 1 = sub
//     input1     in   operand A
//     input2     in   operand B
//     out_valid  out  result valid
//     out_ready  in   consumer accepts result
//     answer     out  result modulo 2^WIDTH
//     carry_out  out  carry out of MSB (sub: 1 = no borrow)
//     overflow   out  signed overflow
//     zero       out  answer == 0
// -----------------------------------------------------------------------------
module addsub_pipe_nbit
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] answer,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("addsub_pipe_nbit: WIDTH (%0d) must be >= 2 and a multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    // Per-stage transaction record. a_rem/b_rem keep the operand chunks not
    // yet consumed (consumed chunks are cleared), sum_done collects result
    // chunks already produced.
    typedef struct packed {
        logic             valid;
        logic             op;
        logic             carry;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_done;
        logic             zero_acc;
    } stage_t;

    stage_t stg_q [STAGES];
    stage_t stg_d [STAGES];
    stage_t src   [STAGES];

    logic                         adv;
    logic                         ovf_q;
    logic                         ovf_d;
    logic [STAGES-1:0][CHUNK-1:0] chunk_a;
    logic [STAGES-1:0][CHUNK-1:0] chunk_b;
    logic [STAGES-1:0][CHUNK-1:0] chunk_sum;
    logic [STAGES-1:0]            chunk_cin;
    logic [STAGES-1:0]            chunk_cout;
    logic [STAGES-1:0]            chunk_cmsb;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0 sources directly from the input port; stage k from register k-1.
    // Since registers only load on adv, in_valid alone is the transfer flag.
    always_comb begin
        src[0].valid    = in_valid;
        src[0].op       = op;
        src[0].carry    = (op == OP_SUB);
        src[0].a_rem    = input1;
        src[0].b_rem    = input2;
        src[0].sum_done = '0;
        src[0].zero_acc = 1'b1;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src[k] = stg_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            chunk_a[k]   = src[k].a_rem[k*CHUNK +: CHUNK];
            chunk_b[k]   = src[k].b_rem[k*CHUNK +: CHUNK] ^ {CHUNK{src[k].op == OP_SUB}};
            chunk_cin[k] = src[k].carry;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a_i   (chunk_a[k]),
            .b_i   (chunk_b[k]),
            .cin_i (chunk_cin[k]),
            .sum_o (chunk_sum[k]),
            .cout_o(chunk_cout[k]),
            .cmsb_o(chunk_cmsb[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            stg_d[k]                             = src[k];
            stg_d[k].carry                       = chunk_cout[k];
            stg_d[k].a_rem[k*CHUNK +: CHUNK]     = '0;
            stg_d[k].b_rem[k*CHUNK +: CHUNK]     = '0;
            stg_d[k].sum_done[k*CHUNK +: CHUNK]  = chunk_sum[k];
            stg_d[k].zero_acc                    = src[k].zero_acc & (chunk_sum[k] == '0);
        end
        // Only the last chunk holds the word MSB, so overflow is formed there.
        ovf_d = chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    // The last stage register doubles as the output register.
    assign out_valid = stg_q[STAGES-1].valid;
    assign answer    = stg_q[STAGES-1].sum_done;
    assign carry_out = stg_q[STAGES-1].carry;
    assign zero      = stg_q[STAGES-1].zero_acc;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_addsub_pipe_nbit.sv
module tb_addsub_pipe_nbit;

    localparam int unsigned N_RAND = 10000;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Shared helpers
    // ------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed observation: {zero, overflow, carry_out, answer}
    function automatic logic [63:0] pack(input logic [31:0] ans, input logic c,
                                         input logic v, input logic z);
        return {29'b0, z, v, c, ans};
    endfunction

    // Reference: plain unsigned/signed integer arithmetic on w-bit values.
    function automatic logic [63:0] ref_model(input int unsigned w, input logic o,
                                              input logic [63:0] x, input logic [63:0] y);
        longint unsigned m, xu, yu, ru;
        longint          half, xs, ys, rs;
        logic            c, v;
        m    = (64'd1 << w) - 64'd1;
        xu   = x & m;
        yu   = y & m;
        ru   = (o ? xu - yu : xu + yu) & m;
        c    = o ? (xu >= yu) : (((xu + yu) >> w) != 64'd0);
        half = longint'(64'd1 << (w - 1));
        xs   = (longint'(xu) >= half) ? longint'(xu) - 2 * half : longint'(xu);
        ys   = (longint'(yu) >= half) ? longint'(yu) - 2 * half : longint'(yu);
        rs   = o ? xs - ys : xs + ys;
        v    = (rs >= half) || (rs < -half);
        return {29'b0, (ru == 64'd0), v, c, ru[31:0]};
    endfunction

    function automatic logic [63:0] rnd_operand(input int unsigned w);
        logic [63:0] m, r;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       r = m;
            1:       r = 64'd0;
            2:       r = 64'd1 << (w - 1);
            3:       r = (64'd1 << (w - 1)) - 64'd1;
            default: r = {$urandom, $urandom};
        endcase
        return r & m;
    endfunction

    // ------------------------------------------------------------------
    // Directed instance: WIDTH=16, STAGES=4
    // ------------------------------------------------------------------
    logic        rst_n, in_valid, in_ready, op, out_valid, out_ready;
    logic        carry_out, overflow, zero;
    logic [15:0] input1, input2, answer;

    addsub_pipe_nbit #(
        .WIDTH (16),
        .STAGES(4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .input1   (input1),
        .input2   (input2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .answer   (answer),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero)
    );

    // Called just after a rising edge with out_ready high and the pipe empty.
    // Latency counts rising edges from the accept edge (inclusive) until
    // out_valid is seen high.
    task automatic run_one(input string tag, input logic o, input logic [15:0] x,
                           input logic [15:0] y, input logic [63:0] exp);
        int unsigned lat;
        in_valid = 1'b1;
        op       = o;
        input1   = x;
        input2   = y;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 4);
        check_eq(tag, pack(answer, carry_out, overflow, zero), exp);
        @(posedge clk);
        #1;
    endtask

    logic        s_op [8];
    logic [15:0] s_a  [8];
    logic [15:0] s_b  [8];

    initial begin
        logic [63:0] exp_q [$];
        logic [63:0] held;
        int unsigned sent, rcvd, idx, seen, wait_cyc;
        logic        stall;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        input1    = '0;
        input2    = '0;
        out_ready = 1'b1;
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_outputs", pack(answer, carry_out, overflow, zero), 0);
        check_eq("rst_in_ready", in_ready, 1);

        // Release just after an edge; the very next edge must accept.
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_one("sub_5_3",    1'b1, 16'h0005, 16'h0003, pack(32'h0002, 1'b1, 1'b0, 1'b0));
        run_one("sub_3_5",    1'b1, 16'h0003, 16'h0005, pack(32'hFFFE, 1'b0, 1'b0, 1'b0));
        run_one("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, pack(32'h8000, 1'b0, 1'b1, 1'b0));
        run_one("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, pack(32'h0000, 1'b1, 1'b0, 1'b1));
        run_one("sub_8000_1", 1'b1, 16'h8000, 16'h0001, pack(32'h7FFF, 1'b1, 1'b1, 1'b0));

        // Back-to-back stream of 8 mixed ops, consumer stalls for cycles 6..8.
        for (int i = 0; i < 8; i++) begin
            s_op[i] = 1'($urandom_range(0, 1));
            s_a[i]  = 16'($urandom);
            s_b[i]  = 16'($urandom);
        end
        sent = 0;
        rcvd = 0;
        held = '0;
        for (int c = 0; c < 40 && rcvd < 8; c++) begin
            stall     = (c >= 6 && c <= 8);
            idx       = (sent < 8) ? sent : 0;
            in_valid  = (sent < 8);
            op        = s_op[idx];
            input1    = s_a[idx];
            input2    = s_b[idx];
            out_ready = !stall;
            @(negedge clk);
            check_eq("stream_in_ready", in_ready, {63'b0, !stall});
            if (stall) begin
                check_eq("stall_out_valid", out_valid, 1);
                if (c == 6) held = pack(answer, carry_out, overflow, zero);
                else        check_eq("stall_hold", pack(answer, carry_out, overflow, zero), held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("stream_spurious", out_valid, 0);
                else begin
                    check_eq("stream_result", pack(answer, carry_out, overflow, zero), exp_q.pop_front());
                    rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(16, op, input1, input2));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("stream_count", rcvd, 8);

        // Three ops in flight, then asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op       = 1'(i);
            input1   = 16'(100 + i);
            input2   = 16'(7 * i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check_eq("pre_reset_out_valid", out_valid, 1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        check_eq("async_rst_out_valid", out_valid, 0);
        check_eq("async_rst_outputs", pack(answer, carry_out, overflow, zero), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("post_reset_quiet", seen, 0);
        @(posedge clk);
        #1;
        run_one("after_reset", 1'b1, 16'h1234, 16'h4321, ref_model(16, 1'b1, 64'h1234, 64'h4321));

        // Wait (bounded) for the randomized configurations.
        wait_cyc = 0;
        while (!(cfg[0].done && cfg[1].done && cfg[2].done) && wait_cyc < 90000) begin
            @(posedge clk);
            wait_cyc++;
        end
        check_eq("random_done", {cfg[2].done, cfg[1].done, cfg[0].done}, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // ------------------------------------------------------------------
    // Randomized instances with random stalls: 16/4, 32/1, 8/8
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int unsigned W = (g == 0) ? 16 : (g == 1) ? 32 : 8;
        localparam int unsigned S = (g == 0) ? 4  : (g == 1) ? 1  : 8;

        logic         rst_n_g, iv, irdy, opv, ov, ordy, co, of, zr;
        logic [W-1:0] a, b, ans;
        bit           done;

        addsub_pipe_nbit #(
            .WIDTH (W),
            .STAGES(S)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n_g),
            .in_valid (iv),
            .in_ready (irdy),
            .op       (opv),
            .input1   (a),
            .input2   (b),
            .out_valid(ov),
            .out_ready(ordy),
            .answer   (ans),
            .carry_out(co),
            .overflow (of),
            .zero     (zr)
        );

        initial begin
            logic [63:0] sb [$];
            logic [63:0] r;
            int unsigned sent, rcvd, cyc, lat;
            string       tg_lat, tg_probe, tg_res, tg_cnt, tg_spur;

            tg_lat   = $sformatf("w%0d_s%0d_latency", W, S);
            tg_probe = $sformatf("w%0d_s%0d_probe", W, S);
            tg_res   = $sformatf("w%0d_s%0d_result", W, S);
            tg_cnt   = $sformatf("w%0d_s%0d_count", W, S);
            tg_spur  = $sformatf("w%0d_s%0d_spurious", W, S);

            done    = 1'b0;
            rst_n_g = 1'b0;
            iv      = 1'b0;
            opv     = 1'b0;
            a       = '0;
            b       = '0;
            ordy    = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n_g = 1'b1;

            // Latency probe on an empty pipe with no stall.
            iv   = 1'b1;
            opv  = 1'b1;
            a    = '1;
            b    = '1;
            ordy = 1'b1;
            @(posedge clk);
            #1 iv = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!ov && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check_eq(tg_lat, lat, S);
            check_eq(tg_probe, pack(ans, co, of, zr), ref_model(W, 1'b1, a, b));
            @(posedge clk);
            #1;

            sent = 0;
            rcvd = 0;
            cyc  = 0;
            while (rcvd < N_RAND && cyc < 60000) begin
                r    = rnd_operand(W);
                a    = r[W-1:0];
                r    = rnd_operand(W);
                b    = r[W-1:0];
                opv  = 1'($urandom_range(0, 1));
                iv   = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (ov && ordy) begin
                    if (sb.size() == 0) check_eq(tg_spur, ov, 0);
                    else begin
                        check_eq(tg_res, pack(ans, co, of, zr), sb.pop_front());
                        rcvd++;
                    end
                end
                if (iv && irdy) begin
                    sb.push_back(ref_model(W, opv, a, b));
                    sent++;
                end
                @(posedge clk);
                #1 cyc++;
            end
            iv = 1'b0;
            check_eq(tg_cnt, rcvd, N_RAND);
            done = 1'b1;
        end
    end

endmodule
